request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Memory-request sequencer consuming the decoder's dREN/dWEN/halt outputs; drives instruction/data
//  requests toward the cache/memory controller and paces the PC. Holds a data request until dhit,
//  latches halt, and keeps saturating stall/retire counters. Sits between control unit, PC, and memory.
// PARAMETERS
//  CNT_W        16   width of istall_cnt / dstall_cnt / retired_cnt
//  TIMEOUT_CYC  1024 consecutive wait cycles in FETCH or DATA before timeout is set
// PORTS
//  CLK          in   1      system clock, rising edge
//  nRST         in   1      reset, asynchronous, active-low
//  ihit         in   1      instruction word valid this cycle
//  dhit         in   1      data access complete this cycle
//  cu_dREN      in   1      decoded load request (valid while ihit)
//  cu_dWEN      in   1      decoded store request (valid while ihit)
//  cu_halt      in   1      decoded HALT (valid while ihit)
//  imemREN      out  1      instruction read request
//  dmemREN      out  1      data read request, registered
//  dmemWEN      out  1      data write request, registered
//  pc_en        out  1      one-cycle pulse: PC advances
//  halt         out  1      sticky halted indication
//  proto_err    out  1      sticky: cu_dREN & cu_dWEN together on an ihit
//  timeout      out  1      sticky: wait exceeded TIMEOUT_CYC
//  istall_cnt   out  CNT_W  cycles in FETCH without ihit, saturating
//  dstall_cnt   out  CNT_W  cycles in DATA without dhit, saturating
//  retired_cnt  out  CNT_W  pc_en pulses, saturating
// BEHAVIOUR
//  - States FETCH, DATA, HALTED. nRST low (any time, incl. mid-DATA): state=FETCH, dmemREN=dmemWEN=0,
//    halt=proto_err=timeout=0, all counters 0, wait counter 0; imemREN=1 and pc_en=0 follow from FETCH.
//  - imemREN = (state==FETCH), combinational. pc_en combinational, never asserted in HALTED.
//  - FETCH, ihit=0: stay; istall_cnt++.
//  - FETCH, ihit & cu_halt: ->HALTED next edge, halt=1; pc_en=0. Halt has priority over dREN/dWEN.
//  - FETCH, ihit & (cu_dREN|cu_dWEN): ->DATA; pc_en=0; next cycle dmemWEN=cu_dWEN,
//    dmemREN=cu_dREN & ~cu_dWEN (write wins); both set -> proto_err=1.
//  - FETCH, ihit, no mem op, no halt: pc_en=1 same cycle; stay FETCH; retired_cnt++.
//  - DATA, dhit=0: hold dmemREN/dmemWEN; dstall_cnt++.
//  - DATA, dhit=1: pc_en=1 same cycle, retired_cnt++; next edge dmemREN=dmemWEN=0, ->FETCH.
//    Earliest back-to-back: ihit cycle, then dhit cycle -> 2-cycle load/store minimum.
//  - dhit in FETCH/HALTED and ihit in DATA/HALTED ignored.
//  - HALTED: terminal until nRST; all requests 0, counters frozen.
//  - Wait counter: cleared on entering FETCH or DATA and on any ihit/dhit; counts otherwise;
//    reaching TIMEOUT_CYC sets timeout (sticky). No state change on timeout.
//  - Counters saturate at all-ones (no wrap).
// STRUCTURE
//  - cpu_types_pkg: typedef enum logic [1:0] {REQ_FETCH, REQ_DATA, REQ_HALTED} reqstate_t.
//  - Sub-module sat_counter #(W) (en, clr, count), instanced for the three statistics counters.
//  - One always_ff for state/flags/dmem regs; one always_comb for next-state, pc_en, imemREN.
// TESTING
//  1 reset: nRST=0 -> imemREN=1, dmemREN=dmemWEN=pc_en=halt=0, all counters 0.
//  2 ALU op: ihit=1 with no dREN/dWEN/halt for 3 cycles -> pc_en=1 each cycle, retired_cnt=3.
//  3 load: ihit+cu_dREN, dhit after 4 cycles -> dmemREN=1 for 5 cycles, imemREN=0, pc_en on dhit only,
//    dstall_cnt=4, then FETCH with dmemREN=0.
//  4 protocol error: ihit+cu_dREN+cu_dWEN -> dmemWEN=1, dmemREN=0, proto_err=1 sticky.
//  5 halt: ihit+cu_halt+cu_dWEN -> HALTED, halt=1, dmemWEN stays 0, later ihit/dhit -> no pc_en.
//  6 reset mid-DATA and timeout: TIMEOUT_CYC=8, no dhit 8 cycles -> timeout=1; nRST pulse -> FETCH, flags 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and default sizing for the request sequencer.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    REQ_FETCH  = 2'd0,
    REQ_DATA   = 2'd1,
    REQ_HALTED = 2'd2
  } reqstate_t;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: fetch/data request pacing, sticky halt/error/timeout
// flags and saturating stall/retire statistics.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             proto_err,
  output logic             timeout,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  reqstate_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_op;
  logic              any_hit;
  logic              issue_op;
  logic              istall_en;
  logic              dstall_en;

  assign mem_op    = cu_dREN | cu_dWEN;
  assign any_hit   = ihit | dhit;
  // Halt wins over a simultaneous memory op on the same fetch.
  assign issue_op  = (state == REQ_FETCH) && ihit && !cu_halt && mem_op;
  assign istall_en = (state == REQ_FETCH) && !ihit;
  assign dstall_en = (state == REQ_DATA) && !dhit;

  // Next state, PC advance and instruction request.
  always_comb begin
    state_nxt = state;
    imemREN   = 1'b0;
    pc_en     = 1'b0;
    case (state)
      REQ_FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (cu_halt)     state_nxt = REQ_HALTED;
          else if (mem_op) state_nxt = REQ_DATA;
          else             pc_en     = 1'b1;
        end
      end
      REQ_DATA: begin
        if (dhit) begin
          pc_en     = 1'b1;
          state_nxt = REQ_FETCH;
        end
      end
      default: ;
    endcase
  end

  // State, sticky flags, data request registers and wait timer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= REQ_FETCH;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      halt      <= 1'b0;
      proto_err <= 1'b0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (issue_op) begin
        dmemWEN <= cu_dWEN;
        dmemREN <= cu_dREN & ~cu_dWEN;
        if (cu_dREN && cu_dWEN) proto_err <= 1'b1;
      end
      if ((state == REQ_DATA) && dhit) begin
        dmemREN <= 1'b0;
        dmemWEN <= 1'b0;
      end
      if ((state == REQ_FETCH) && ihit && cu_halt) halt <= 1'b1;
      // Every FETCH/DATA transition is caused by a hit, so clearing on hits covers state entry.
      if (state != REQ_HALTED) begin
        if (any_hit) begin
          wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(TIMEOUT_CYC)) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_istall (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (istall_en),
    .clr   (1'b0),
    .count (istall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_dstall (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (dstall_en),
    .clr   (1'b0),
    .count (dstall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retired (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (pc_en),
    .clr   (1'b0),
    .count (retired_cnt)
  );

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit against a transaction-level model of the sequencer.
module tb_request_unit;

  localparam int unsigned CNT_W = 16;
  localparam int          TMO   = 8;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, cu_dREN, cu_dWEN, cu_halt;
  logic             imemREN, dmemREN, dmemWEN, pc_en, halt, proto_err, timeout;
  logic [CNT_W-1:0] istall_cnt, dstall_cnt, retired_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: a pending memory op (busy/rd/wr), halted flag, sticky flags, counters.
  bit m_busy, m_rd, m_wr, m_halted, m_perr, m_tmo, in_rst;
  int m_ist, m_dst, m_ret, m_wait;

  request_unit #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .cu_dREN     (cu_dREN),
    .cu_dWEN     (cu_dWEN),
    .cu_halt     (cu_halt),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .pc_en       (pc_en),
    .halt        (halt),
    .proto_err   (proto_err),
    .timeout     (timeout),
    .istall_cnt  (istall_cnt),
    .dstall_cnt  (dstall_cnt),
    .retired_cnt (retired_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_wr = 0; m_halted = 0; m_perr = 0; m_tmo = 0;
    m_ist = 0; m_dst = 0; m_ret = 0; m_wait = 0;
  endtask

  function automatic int bump(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  // Advance the model by one clock edge given the inputs held during the cycle.
  task automatic model_step();
    if (m_halted) return;
    if (!m_busy) begin
      if (ihit) begin
        if (cu_halt) m_halted = 1;
        else if (cu_dREN || cu_dWEN) begin
          m_busy = 1;
          m_wr   = cu_dWEN;
          m_rd   = cu_dREN && !cu_dWEN;
          if (cu_dREN && cu_dWEN) m_perr = 1;
        end else m_ret = bump(m_ret);
      end else m_ist = bump(m_ist);
    end else begin
      if (dhit) begin
        m_ret  = bump(m_ret);
        m_busy = 0; m_rd = 0; m_wr = 0;
      end else m_dst = bump(m_dst);
    end
    if (ihit || dhit) m_wait = 0;
    else begin
      if (m_wait < TMO) m_wait++;
      if (m_wait == TMO) m_tmo = 1;
    end
  endtask

  task automatic compare_all();
    bit exp_imem, exp_pc;
    exp_imem = !m_busy && !m_halted;
    exp_pc   = (exp_imem && ihit && !cu_halt && !cu_dREN && !cu_dWEN) || (m_busy && dhit);
    chk("imemREN",     int'(imemREN),     int'(exp_imem));
    chk("pc_en",       int'(pc_en),       int'(exp_pc));
    chk("dmemREN",     int'(dmemREN),     int'(m_rd));
    chk("dmemWEN",     int'(dmemWEN),     int'(m_wr));
    chk("halt",        int'(halt),        int'(m_halted));
    chk("proto_err",   int'(proto_err),   int'(m_perr));
    chk("timeout",     int'(timeout),     int'(m_tmo));
    chk("istall_cnt",  int'(istall_cnt),  m_ist);
    chk("dstall_cnt",  int'(dstall_cnt),  m_dst);
    chk("retired_cnt", int'(retired_cnt), m_ret);
  endtask

  // One cycle: drive just after the edge, compare mid-cycle, advance model at the edge.
  task automatic cyc(input bit i, input bit d, input bit r, input bit w, input bit h);
    ihit = i; dhit = d; cu_dREN = r; cu_dWEN = w; cu_halt = h;
    #4;
    compare_all();
    @(posedge CLK);
    if (!in_rst) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic assert_reset();
    nRST = 1'b0; in_rst = 1; model_reset();
    ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;
  endtask

  initial begin
    assert_reset();
    @(posedge CLK);
    #1;
    // Reset state
    idle(2);
    chk("rst_imemREN", int'(imemREN), 1);
    chk("rst_retired", int'(retired_cnt), 0);
    nRST = 1'b1; in_rst = 0;

    // Straight-line ALU ops retire every cycle
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("alu_retired", int'(retired_cnt), 3);

    // Load with four stall cycles
    cyc(1, 0, 1, 0, 0);
    chk("ld_dmemREN", int'(dmemREN), 1);
    chk("ld_imemREN", int'(imemREN), 0);
    idle(4);
    cyc(0, 1, 0, 0, 0);
    chk("ld_dstall", int'(dstall_cnt), 4);
    chk("ld_retired", int'(retired_cnt), 4);
    chk("ld_done_dmemREN", int'(dmemREN), 0);

    // Load+store together: write wins, error latched
    cyc(1, 0, 1, 1, 0);
    chk("pe_dmemWEN", int'(dmemWEN), 1);
    chk("pe_dmemREN", int'(dmemREN), 0);
    chk("pe_flag", int'(proto_err), 1);
    cyc(1, 1, 0, 0, 0);
    idle(2);
    chk("pe_sticky", int'(proto_err), 1);
    chk("pe_istall", int'(istall_cnt), 2);

    // Halt beats the store; hits afterwards are ignored
    cyc(1, 0, 0, 1, 1);
    chk("hlt_halt", int'(halt), 1);
    chk("hlt_dmemWEN", int'(dmemWEN), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(2);
    chk("hlt_retired", int'(retired_cnt), 5);
    chk("hlt_imemREN", int'(imemREN), 0);

    // Timeout in DATA, then reset mid-DATA
    assert_reset();
    idle(1);
    nRST = 1'b1; in_rst = 0;
    cyc(1, 0, 1, 0, 0);
    idle(TMO - 1);
    chk("tmo_before", int'(timeout), 0);
    idle(1);
    chk("tmo_set", int'(timeout), 1);
    idle(2);
    chk("tmo_sticky", int'(timeout), 1);
    assert_reset();
    idle(1);
    chk("mid_rst_dmemREN", int'(dmemREN), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    chk("mid_rst_imemREN", int'(imemREN), 1);
    nRST = 1'b1; in_rst = 0;
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_retired", int'(retired_cnt), 1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
